// File: rtl/rv_fetch_expander.sv
// Fetch-to-decode realigner: buffers fetch words as 16-bit parcels, stitches
// instructions that straddle words and expands RVC encodings to 32-bit form.
module rv_fetch_expander #(
    parameter int          DEPTH    = 4,
    parameter bit          ENABLE_F = 1'b1,
    parameter bit          ENABLE_D = 1'b1,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_data,
    output logic [31:0] fetch_addr,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_compressed,
    output logic        inst_sigill
);
    localparam int NP = 2 * DEPTH;
    localparam int PW = $clog2(NP);

    typedef enum logic {RUN, SKIP} state_t;

    logic [15:0]   ring [NP];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count, add_n, sub_n, need;
    logic [31:0]   head_pc;
    state_t        state;

    logic [15:0]   p0, p1;
    logic          is32, accept, consume;
    logic [32:0]   expanded;

    // Returns {illegal, expanded instruction}; illegal encodings yield 32'h0.
    function automatic logic [32:0] expand(input logic [15:0] c);
        logic [31:0] r;
        logic        ill;
        logic [4:0]  rd, rs2, rdp, rs1p;
        logic [11:0] imm6, off;
        logic [20:0] jimm;
        logic [12:0] bimm;
        r    = 32'h0;
        ill  = 1'b0;
        rd   = c[11:7];
        rs2  = c[6:2];
        rdp  = {2'b01, c[4:2]};
        rs1p = {2'b01, c[9:7]};
        imm6 = {{6{c[12]}}, c[12], c[6:2]};
        jimm = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
        bimm = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3], 1'b0};
        off  = 12'h0;
        case ({c[1:0], c[15:13]})
            5'b00_000: begin
                ill = (c == 16'h0);
                r   = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, 7'h13};
            end
            5'b00_001: begin
                off = {4'b0, c[6:5], c[12:10], 3'b0};
                r   = {off, rs1p, 3'b011, rdp, 7'h07};
                ill = !ENABLE_D;
            end
            5'b00_010, 5'b00_011: begin
                off = {5'b0, c[5], c[12:10], c[6], 2'b0};
                r   = {off, rs1p, 3'b010, rdp, c[13] ? 7'h07 : 7'h03};
                ill = c[13] && !ENABLE_F;
            end
            5'b00_100: ill = 1'b1;
            5'b00_101: begin
                off = {4'b0, c[6:5], c[12:10], 3'b0};
                r   = {off[11:5], rdp, rs1p, 3'b011, off[4:0], 7'h27};
                ill = !ENABLE_D;
            end
            5'b00_110, 5'b00_111: begin
                off = {5'b0, c[5], c[12:10], c[6], 2'b0};
                r   = {off[11:5], rdp, rs1p, 3'b010, off[4:0], c[13] ? 7'h27 : 7'h23};
                ill = c[13] && !ENABLE_F;
            end
            5'b01_000: r = {imm6, rd, 3'b000, rd, 7'h13};
            5'b01_001: r = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd1, 7'h6F};
            5'b01_010: r = {imm6, 5'd0, 3'b000, rd, 7'h13};
            5'b01_011: begin
                if (rd == 5'd2)
                    r = {{2{c[12]}}, c[12], c[4:3], c[5], c[2], c[6], 4'b0, 5'd2, 3'b000, 5'd2, 7'h13};
                else
                    r = {{14{c[12]}}, c[12], c[6:2], rd, 7'h37};
            end
            5'b01_100: begin
                case (c[11:10])
                    2'b00: r = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
                    2'b01: r = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
                    2'b10: r = {imm6, rs1p, 3'b111, rs1p, 7'h13};
                    default: begin
                        ill = c[12];
                        case (c[6:5])
                            2'b00:   r = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'h33};
                            2'b01:   r = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'h33};
                            2'b10:   r = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'h33};
                            default: r = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'h33};
                        endcase
                    end
                endcase
            end
            5'b01_101: r = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd0, 7'h6F};
            5'b01_110, 5'b01_111:
                r = {bimm[12], bimm[10:5], 5'd0, rs1p, 2'b00, c[13], bimm[4:1], bimm[11], 7'h63};
            5'b10_000: r = {7'b0, c[6:2], rd, 3'b001, rd, 7'h13};
            5'b10_001: begin
                r   = {3'b0, c[4:2], c[12], c[6:5], 3'b0, 5'd2, 3'b011, rd, 7'h07};
                ill = !ENABLE_D;
            end
            5'b10_010, 5'b10_011: begin
                r   = {4'b0, c[3:2], c[12], c[6:4], 2'b0, 5'd2, 3'b010, rd, c[13] ? 7'h07 : 7'h03};
                ill = c[13] && !ENABLE_F;
            end
            5'b10_100: begin
                if (!c[12]) begin
                    if (rs2 == 5'd0) begin
                        ill = (rd == 5'd0);
                        r   = {12'h0, rd, 3'b000, 5'd0, 7'h67};
                    end else
                        r = {7'b0, rs2, 5'd0, 3'b000, rd, 7'h33};
                end else if (rs2 == 5'd0)
                    r = (rd == 5'd0) ? 32'h0010_0073 : {12'h0, rd, 3'b000, 5'd1, 7'h67};
                else
                    r = {7'b0, rs2, rd, 3'b000, rd, 7'h33};
            end
            5'b10_101: begin
                off = {3'b0, c[9:7], c[12:10], 3'b0};
                r   = {off[11:5], rs2, 5'd2, 3'b011, off[4:0], 7'h27};
                ill = !ENABLE_D;
            end
            5'b10_110, 5'b10_111: begin
                off = {4'b0, c[8:7], c[12:9], 2'b0};
                r   = {off[11:5], rs2, 5'd2, 3'b010, off[4:0], c[13] ? 7'h27 : 7'h23};
                ill = c[13] && !ENABLE_F;
            end
            default: r = 32'h0;
        endcase
        if (ill) r = 32'h0;
        return {ill, r};
    endfunction

    assign p0       = ring[rd_ptr];
    assign p1       = ring[rd_ptr + PW'(1)];
    assign is32     = (p0[1:0] == 2'b11);
    assign need     = is32 ? (PW+1)'(2) : (PW+1)'(1);
    assign expanded = expand(p0);

    assign fetch_ready     = (count <= (PW+1)'(NP - 2));
    assign inst_valid      = (count >= need);
    assign inst            = is32 ? {p1, p0} : expanded[31:0];
    assign inst_pc         = head_pc;
    assign inst_compressed = !is32;
    assign inst_sigill     = !is32 && expanded[32];

    assign accept  = fetch_valid && fetch_ready;
    assign consume = inst_valid && inst_ready;
    assign add_n   = !accept ? '0 : (state == SKIP) ? (PW+1)'(1) : (PW+1)'(2);
    assign sub_n   = consume ? need : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_pc    <= RESET_PC;
            fetch_addr <= {RESET_PC[31:2], 2'b00};
            state      <= RESET_PC[1] ? SKIP : RUN;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_pc    <= flush_pc & 32'hFFFF_FFFE;
            fetch_addr <= flush_pc & 32'hFFFF_FFFC;
            state      <= flush_pc[1] ? SKIP : RUN;
        end else begin
            if (accept) begin
                fetch_addr <= fetch_addr + 32'd4;
                wr_ptr     <= wr_ptr + add_n[PW-1:0];
                state      <= RUN;
            end
            if (consume) begin
                rd_ptr  <= rd_ptr + need[PW-1:0];
                head_pc <= head_pc + (is32 ? 32'd4 : 32'd2);
            end
            count <= count + add_n - sub_n;
        end
    end

    // Parcel storage carries no reset; pointers and count define what is live.
    always_ff @(posedge clock) begin
        if (accept) begin
            if (state == SKIP) begin
                ring[wr_ptr] <= fetch_data[31:16];
            end else begin
                ring[wr_ptr]           <= fetch_data[15:0];
                ring[wr_ptr + PW'(1)]  <= fetch_data[31:16];
            end
        end
    end
endmodule
